rom_sequencer: RTL

ROM_SEQUENCER -- requirements
Module: rom_sequencer

---
 rtl/rom_seq_pkg.sv | 69 ++++++
 rtl/rom_seq_stack.sv | 53 +++++
 rtl/rom_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM-driven byte sequencer: FSM states,
// opcode values/masks, error codes and the opcode classifier.
package rom_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_IMM1,
        S_IMM2,
        S_SEND,
        S_LOAD
    } state_t;

    // Opcode base values
    localparam logic [7:0] OP_HALT = 8'h00;
    localparam logic [7:0] OP_JUMP = 8'h01;
    localparam logic [7:0] OP_CALL = 8'h02;
    localparam logic [7:0] OP_RET  = 8'h03;
    localparam logic [7:0] OP_MOV  = 8'h04;
    localparam logic [7:0] OP_SEND = 8'h08;
    localparam logic [7:0] OP_DEC  = 8'h0C;
    localparam logic [7:0] OP_JNZ  = 8'h10;
    localparam logic [7:0] OP_INC  = 8'h18;
    localparam logic [7:0] OP_ADD  = 8'h80;
    localparam logic [7:0] OP_LD   = 8'hC0;

    // Opcode masks: exact match, one 2-bit register field, two register fields
    localparam logic [7:0] MASK_EXACT = 8'hFF;
    localparam logic [7:0] MASK_REG   = 8'hFC;
    localparam logic [7:0] MASK_PAIR  = 8'hF0;

    // Sticky error codes
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

    typedef enum logic [3:0] {
        C_HALT,
        C_JUMP,
        C_CALL,
        C_RET,
        C_MOV,
        C_SEND,
        C_DEC,
        C_JNZ,
        C_INC,
        C_ADD,
        C_LD,
        C_ILLEGAL
    } op_class_t;

    function automatic op_class_t decode_op(input logic [7:0] op);
        if ((op & MASK_EXACT) == OP_HALT) return C_HALT;
        if ((op & MASK_EXACT) == OP_JUMP) return C_JUMP;
        if ((op & MASK_EXACT) == OP_CALL) return C_CALL;
        if ((op & MASK_EXACT) == OP_RET)  return C_RET;
        if ((op & MASK_REG)   == OP_MOV)  return C_MOV;
        if ((op & MASK_REG)   == OP_SEND) return C_SEND;
        if ((op & MASK_REG)   == OP_DEC)  return C_DEC;
        if ((op & MASK_REG)   == OP_JNZ)  return C_JNZ;
        if ((op & MASK_REG)   == OP_INC)  return C_INC;
        if ((op & MASK_PAIR)  == OP_ADD)  return C_ADD;
        if ((op & MASK_PAIR)  == OP_LD)   return C_LD;
        return C_ILLEGAL;
    endfunction

endpackage

// File: rtl/rom_seq_stack.sv
// Return-address LIFO for CALL/RET. The top entry is presented
// combinationally; push and pop are ignored when full / empty.
module rom_seq_stack
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int unsigned SP_W = $clog2(DEPTH + 1);

    logic [SP_W-1:0]   sp;
    logic [ADDR_W-1:0] mem [DEPTH];

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);

    // Select the most recently pushed entry
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) top = mem[i];
        end
    end

    // Stack pointer and storage update
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (push && !full) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (sp == SP_W'(i)) mem[i] <= push_data;
            end
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

endmodule

// File: rtl/rom_sequencer.sv
// Tiny ROM-program interpreter that emits bytes toward a UART sink.
// Every ROM byte takes a FETCH cycle (address out) followed by one
// consuming cycle (DECODE, IMM1, IMM2 or LOAD) that sees the data.
module rom_sequencer
    import rom_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 9,
    parameter int unsigned       STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);

    state_t            state;
    state_t            consume;   // state entered after the next FETCH
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resume_pc; // pc to return to after a LD data fetch
    logic [7:0]        opcode;
    logic [7:0]        imm_lo;
    logic [7:0]        regs [4];

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ld_addr;
    op_class_t         dec_class;
    op_class_t         imm_class;

    logic              stk_push;
    logic              stk_pop;
    logic              stk_clear;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_full;
    logic              stk_empty;

    assign rom_addr = pc;
    assign busy     = (state != S_IDLE);
    assign pc_inc   = pc + ADDR_W'(1);
    assign target   = ADDR_W'({rom_data, imm_lo});
    assign ld_addr  = ADDR_W'({regs[rom_data[1:0] | 2'b01], regs[rom_data[1:0] & 2'b10]});

    // Classify the byte being decoded and the opcode awaiting its operands
    always_comb begin
        dec_class = decode_op(rom_data);
        imm_class = decode_op(opcode);
    end

    // Stack requests: push after the CALL high byte, pop on RET decode
    always_comb begin
        stk_clear = (state == S_IDLE) && start;
        stk_push  = (state == S_IMM2) && (imm_class == C_CALL) && !stk_full;
        stk_pop   = (state == S_DECODE) && (dec_class == C_RET) && !stk_empty;
    end

    rom_seq_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .resetq    (resetq),
        .clear     (stk_clear),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // Main sequencer: fetch/consume alternation, execution and output handshake
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state     <= S_IDLE;
            consume   <= S_DECODE;
            pc        <= START_ADDR;
            resume_pc <= START_ADDR;
            opcode    <= '0;
            imm_lo    <= '0;
            for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= ERR_NONE;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= START_ADDR;
                        err     <= ERR_NONE;
                        consume <= S_DECODE;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: state <= consume;
                S_DECODE: begin
                    opcode  <= rom_data;
                    pc      <= pc_inc;
                    state   <= S_FETCH;
                    consume <= S_DECODE;
                    case (dec_class)
                        C_HALT: begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                        C_JUMP, C_CALL, C_JNZ, C_MOV: consume <= S_IMM1;
                        C_RET: begin
                            if (stk_empty) begin
                                err   <= ERR_UNDERFLOW;
                                state <= S_IDLE;
                            end else begin
                                pc <= stk_top;
                            end
                        end
                        C_SEND: begin
                            out_data  <= regs[rom_data[1:0]];
                            out_valid <= 1'b1;
                            state     <= S_SEND;
                        end
                        C_DEC: regs[rom_data[1:0]] <= regs[rom_data[1:0]] - 8'd1;
                        C_INC: regs[rom_data[1:0]] <= regs[rom_data[1:0]] + 8'd1;
                        C_ADD: regs[rom_data[3:2]] <= regs[rom_data[3:2]] + regs[rom_data[1:0]];
                        C_LD: begin
                            // Borrow pc for the data fetch; the real pc is parked
                            resume_pc <= pc_inc;
                            pc        <= ld_addr;
                            consume   <= S_LOAD;
                        end
                        default: begin
                            err   <= ERR_ILLEGAL;
                            state <= S_IDLE;
                        end
                    endcase
                end
                S_IMM1: begin
                    pc    <= pc_inc;
                    state <= S_FETCH;
                    if (imm_class == C_MOV) begin
                        regs[opcode[1:0]] <= rom_data;
                        consume           <= S_DECODE;
                    end else begin
                        imm_lo  <= rom_data;
                        consume <= S_IMM2;
                    end
                end
                S_IMM2: begin
                    state   <= S_FETCH;
                    consume <= S_DECODE;
                    case (imm_class)
                        C_JUMP: pc <= target;
                        C_CALL: begin
                            if (stk_full) begin
                                err   <= ERR_OVERFLOW;
                                state <= S_IDLE;
                            end else begin
                                pc <= target;
                            end
                        end
                        C_JNZ:   pc <= (regs[opcode[1:0]] != 8'd0) ? target : pc_inc;
                        default: pc <= pc_inc;
                    endcase
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        consume   <= S_DECODE;
                        state     <= S_FETCH;
                    end
                end
                S_LOAD: begin
                    regs[opcode[3:2]] <= rom_data;
                    pc                <= resume_pc;
                    consume           <= S_DECODE;
                    state             <= S_FETCH;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
